// File: rtl/uart_pkg.sv
// Shared types and constants for the UART MMIO front-end.
// One-hot FSM encodings, STATUS bit positions, register offsets and TX start timeout.
package uart_pkg;

    typedef enum logic [1:0] {
        B_IDLE = 2'b01,
        B_RESP = 2'b10
    } bus_state_t;

    typedef enum logic [3:0] {
        T_IDLE    = 4'b0001,
        T_START   = 4'b0010,
        T_WAIT_HI = 4'b0100,
        T_WAIT_LO = 4'b1000
    } tx_state_t;

    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_TX_FULL  = 2;
    localparam int ST_RX_ERR   = 3;
    localparam int ST_OVERRUN  = 4;
    localparam int ST_TX_BUSY  = 5;

    localparam logic [31:0] UART_DATA_OFS = 32'd0;
    localparam logic [31:0] UART_CTL_OFS  = 32'd4;
    localparam int          TX_START_TIMEOUT = 4;

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// CPU mem_valid/mem_ready bus bundle; master = CPU side, slave = peripheral side.
interface uart_mmio_ctrl_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                    output mem_ready, mem_rdata);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO: push/pop same cycle allowed even when full.
// Latency: data visible on pop_dat_o the cycle after push; push ignored when full without pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO front-end for the uart core: TX FIFO + sequencer, RX holding register, STATUS/CTL.
// Bus response 1 cycle after accept; DATA writes stall (no mem_ready) while the TX FIFO is full.
// Optional interrupt output and IE bits controlled by macro UART_MMIO_IRQ_EN.
module uart_mmio_ctrl
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'hF000_0000,
    parameter int          TX_FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    uart_mmio_ctrl_if.slave        bus,
    output logic                   uart_transmit,
    output logic [7:0]             uart_tx_byte,
    input  logic                   uart_is_tx,
    input  logic                   uart_received,
    input  logic [7:0]             uart_rx_byte,
    input  logic                   uart_recv_error
`ifdef UART_MMIO_IRQ_EN
    ,
    output logic                   irq
`endif
);
    bus_state_t  bus_state_q, bus_state_d;
    tx_state_t   tx_state_q, tx_state_d;
    logic        skip_q, skip_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  tx_cnt_q, tx_cnt_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_err_q, rx_err_d;
    logic        overrun_q, overrun_d;
    logic [1:0]  ie_q, ie_d;

    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic        data_rd, ctl_wr, is_wr, hit_data, hit_ctl, tx_busy, rx_take;
    logic [31:0] status;
    logic        unused_wdata;

    assign unused_wdata = ^{bus.mem_wdata[31:8], bus.mem_wdata[0]};

    sync_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (fifo_push),
        .push_dat_i (bus.mem_wdata[7:0]),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dout),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign is_wr    = |bus.mem_wstrb;
    assign hit_data = (bus.mem_addr == BASE_ADDR + UART_DATA_OFS);
    assign hit_ctl  = (bus.mem_addr == BASE_ADDR + UART_CTL_OFS);
    assign tx_busy  = (tx_state_q != T_IDLE);
    assign rx_take  = uart_received && !uart_recv_error;

    always_comb begin
        status = '0;
        status[ST_RX_VALID] = rx_valid_q;
        status[ST_TX_EMPTY] = fifo_empty;
        status[ST_TX_FULL]  = fifo_full;
        status[ST_RX_ERR]   = rx_err_q;
        status[ST_OVERRUN]  = overrun_q;
        status[ST_TX_BUSY]  = tx_busy;
`ifdef UART_MMIO_IRQ_EN
        status[7:6] = ie_q;
`endif
    end

    // skip_q marks the cycle right after a response, so a still-held valid is not re-executed.
    always_comb begin
        bus_state_d = bus_state_q;
        skip_d      = 1'b0;
        rdata_d     = rdata_q;
        fifo_push   = 1'b0;
        data_rd     = 1'b0;
        ctl_wr      = 1'b0;
        case (bus_state_q)
            B_IDLE: begin
                if (bus.mem_valid && !skip_q) begin
                    if (hit_data && is_wr) begin
                        if (!fifo_full || fifo_pop) begin
                            fifo_push   = 1'b1;
                            rdata_d     = '0;
                            bus_state_d = B_RESP;
                        end
                    end else begin
                        bus_state_d = B_RESP;
                        rdata_d     = '0;
                        if (hit_data) begin
                            data_rd = 1'b1;
                            rdata_d = {24'h0, rx_byte_q};
                        end else if (hit_ctl) begin
                            if (is_wr) ctl_wr  = 1'b1;
                            else       rdata_d = status;
                        end
                    end
                end
            end
            B_RESP: begin
                bus_state_d = B_IDLE;
                skip_d      = 1'b1;
                rdata_d     = '0;
            end
            default: bus_state_d = B_IDLE;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_byte_d  = tx_byte_q;
        fifo_pop   = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_byte_d  = fifo_dout;
                    tx_state_d = T_START;
                end
            end
            T_START: begin
                tx_cnt_d   = '0;
                tx_state_d = T_WAIT_HI;
            end
            T_WAIT_HI: begin
                if (uart_is_tx)                                 tx_state_d = T_WAIT_LO;
                else if (tx_cnt_q == 3'(TX_START_TIMEOUT - 1))  tx_state_d = T_IDLE;
                else                                            tx_cnt_d   = tx_cnt_q + 3'd1;
            end
            T_WAIT_LO: begin
                if (!uart_is_tx) tx_state_d = T_IDLE;
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // Set events are applied after clears so a same-cycle set wins.
    always_comb begin
        rx_byte_d  = rx_take ? uart_rx_byte : rx_byte_q;
        rx_valid_d = rx_valid_q;
        rx_err_d   = rx_err_q;
        overrun_d  = overrun_q;
        ie_d       = ie_q;
        if (data_rd) rx_valid_d = 1'b0;
        if (rx_take) rx_valid_d = 1'b1;
        if (ctl_wr && bus.mem_wdata[1]) rx_err_d  = 1'b0;
        if (ctl_wr && bus.mem_wdata[2]) overrun_d = 1'b0;
        if (uart_recv_error) rx_err_d = 1'b1;
        if (rx_take && rx_valid_q && !data_rd) overrun_d = 1'b1;
`ifdef UART_MMIO_IRQ_EN
        if (ctl_wr) ie_d = bus.mem_wdata[4:3];
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus_state_q <= B_IDLE;
            tx_state_q  <= T_IDLE;
            skip_q      <= 1'b0;
            rdata_q     <= '0;
            tx_cnt_q    <= '0;
            tx_byte_q   <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_err_q    <= 1'b0;
            overrun_q   <= 1'b0;
            ie_q        <= '0;
        end else begin
            bus_state_q <= bus_state_d;
            tx_state_q  <= tx_state_d;
            skip_q      <= skip_d;
            rdata_q     <= rdata_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_byte_q   <= tx_byte_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            rx_err_q    <= rx_err_d;
            overrun_q   <= overrun_d;
            ie_q        <= ie_d;
        end
    end

`ifdef UART_MMIO_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk) begin
        if (!reset_n) irq_q <= 1'b0;
        else          irq_q <= (ie_d[0] & rx_valid_d) | (ie_d[1] & fifo_empty & ~tx_busy);
    end
    assign irq = irq_q;
`endif

    assign bus.mem_ready = (bus_state_q == B_RESP);
    assign bus.mem_rdata = (bus_state_q == B_RESP) ? rdata_q : '0;
    assign uart_transmit = (tx_state_q == T_START);
    assign uart_tx_byte  = tx_byte_q;
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl with a transmit scoreboard and a simple uart core model.
module tb_uart_mmio_ctrl;
    localparam logic [31:0] BASE = 32'hF000_0000;
    localparam logic [31:0] DATA = BASE;
    localparam logic [31:0] CTL  = BASE + 32'd4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       uart_transmit;
    logic [7:0] uart_tx_byte;
    logic       is_tx;
    logic       received;
    logic [7:0] rx_byte;
    logic       recv_err;
`ifdef UART_MMIO_IRQ_EN
    logic       irq;
`endif

    int         tests = 0;
    int         fails = 0;
    int         pulses = 0;
    int         busy_cnt = 0;
    logic       hold_busy = 1'b0;
    logic [7:0] exp_q[$];

    uart_mmio_ctrl_if bus();

    uart_mmio_ctrl #(.BASE_ADDR(BASE), .TX_FIFO_DEPTH(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus),
        .uart_transmit   (uart_transmit),
        .uart_tx_byte    (uart_tx_byte),
        .uart_is_tx      (is_tx),
        .uart_received   (received),
        .uart_rx_byte    (rx_byte),
        .uart_recv_error (recv_err)
`ifdef UART_MMIO_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] rdata, output int lat);
        logic got;
        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            got = bus.mem_ready;
        end
        rdata = bus.mem_rdata;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        tests++;
        assert (got === 1'b1) else begin
            fails++;
            $error("FAIL bus_timeout: addr %h no mem_ready after %0d cycles", addr, lat);
        end
    endtask

    task automatic wr_data(input logic [7:0] b);
        logic [31:0] rd;
        int lat;
        exp_q.push_back(b);
        bus_xfer(DATA, {24'h0, b}, 4'hF, rd, lat);
    endtask

    task automatic rd_reg(input logic [31:0] addr, output logic [31:0] rd);
        int lat;
        bus_xfer(addr, 32'h0, 4'h0, rd, lat);
    endtask

    task automatic wr_ctl(input logic [31:0] v);
        logic [31:0] rd;
        int lat;
        bus_xfer(CTL, v, 4'hF, rd, lat);
    endtask

    task automatic rx_pulse(input logic [7:0] b, input logic err);
        @(negedge clk);
        received = !err;
        recv_err = err;
        rx_byte  = b;
        @(negedge clk);
        received = 1'b0;
        recv_err = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || is_tx) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    // Core model + scoreboard: checks each start pulse, then holds is_tx for 10 cycles.
    initial begin
        logic [7:0] e;
        is_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_transmit === 1'b1) begin
                pulses++;
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL tx_unexpected: observed byte %h expected no transmit", uart_tx_byte);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tx_byte", {24'h0, uart_tx_byte}, {24'h0, e});
                end
                check("tx_after_idle", {31'h0, is_tx}, 32'h0);
                busy_cnt = 10;
            end else if (busy_cnt != 0) begin
                busy_cnt--;
            end
            is_tx = (busy_cnt != 0) || hold_busy;
        end
    end

    initial begin
        logic [31:0] rd;
        int lat, p0;
        logic done;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        received = 1'b0;
        recv_err = 1'b0;
        rx_byte  = '0;
        reset_n  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", {31'h0, bus.mem_ready}, 32'h0);
        check("rst_rdata", bus.mem_rdata, 32'h0);
        check("rst_transmit", {31'h0, uart_transmit}, 32'h0);
        check("rst_tx_byte", {24'h0, uart_tx_byte}, 32'h0);

        bus_xfer(CTL, 32'h0, 4'h0, rd, lat);
        check("status_reset", rd, 32'h2);
        check("read_latency", lat, 1);
        @(posedge clk); #1;
        check("ready_one_cycle", {31'h0, bus.mem_ready}, 32'h0);

        p0 = pulses;
        wr_data(8'h41);
        wr_data(8'h42);
        wr_data(8'h43);
        wait_drain("abc_drain");
        check("abc_pulses", pulses - p0, 3);

        p0 = pulses;
        wr_data(8'h60);
        lat = 0;
        while (pulses == p0 && lat < 100) begin @(negedge clk); lat++; end
        hold_busy = 1'b1;
        for (int i = 1; i <= 8; i++) wr_data(8'(8'h60 + i));
        rd_reg(CTL, rd);
        check("status_full", rd, 32'h24);
        done = 1'b0;
        exp_q.push_back(8'h69);
        fork
            begin
                logic [31:0] r9;
                int l9;
                bus_xfer(DATA, 32'h69, 4'hF, r9, l9);
                done = 1'b1;
            end
        join_none
        repeat (20) @(negedge clk);
        check("full_stall", {31'h0, done}, 32'h0);
        hold_busy = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin @(negedge clk); lat++; end
        check("full_release", {31'h0, done}, 32'h1);
        wait_drain("full_drain");
        check("full_pulses", pulses - p0, 10);

        rx_pulse(8'h5A, 1'b0);
        rx_pulse(8'h33, 1'b0);
        rd_reg(CTL, rd);
        check("status_overrun", rd, 32'h13);
        rd_reg(DATA, rd);
        check("data_latest", rd, 32'h33);
        rd_reg(CTL, rd);
        check("status_after_read", rd, 32'h12);
        wr_ctl(32'h4);
        rd_reg(CTL, rd);
        check("overrun_clear", rd, 32'h02);
        rx_pulse(8'hEE, 1'b1);
        rd_reg(CTL, rd);
        check("status_rx_err", rd, 32'h0A);
        wr_ctl(32'h2);
        rd_reg(CTL, rd);
        check("rx_err_clear", rd, 32'h02);
        rd_reg(BASE + 32'h10, rd);
        check("unmapped_read", rd, 32'h0);

        rx_pulse(8'h55, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = DATA;
        bus.mem_wstrb = 4'h0;
        received = 1'b1;
        rx_byte  = 8'h77;
        @(posedge clk); #1;
        received = 1'b0;
        check("coinc_ready", {31'h0, bus.mem_ready}, 32'h1);
        check("coinc_old_byte", bus.mem_rdata, 32'h55);
        bus.mem_valid = 1'b0;
        rd_reg(CTL, rd);
        check("coinc_rx_valid", rd & 32'h1, 32'h1);
        rd_reg(DATA, rd);
        check("coinc_new_byte", rd, 32'h77);

`ifdef UART_MMIO_IRQ_EN
        wr_ctl(32'h08);
        rx_pulse(8'h11, 1'b0);
        repeat (2) @(negedge clk);
        check("irq_set", {31'h0, irq}, 32'h1);
        rd_reg(DATA, rd);
        @(posedge clk); #1;
        check("irq_clear", {31'h0, irq}, 32'h0);
        wr_ctl(32'h0);
`endif

        wr_data(8'h71);
        wr_data(8'h72);
        wr_data(8'h73);
        wr_data(8'h74);
        lat = 0;
        while (!is_tx && lat < 100) begin @(negedge clk); lat++; end
        @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        p0 = pulses;
        rd_reg(CTL, rd);
        check("reset_tx_empty", rd, 32'h02);
        repeat (60) @(negedge clk);
        check("reset_no_pulses", pulses - p0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
